// File: rtl/arm_pkg.sv
// Shared ARM core definitions: condition codes, NZCV bit positions, FlagW fields.
package arm_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned COND_W  = 4;

  // Condition-field encodings (instruction bits [31:28])
  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_AL = 4'hE;
  localparam logic [COND_W-1:0] COND_NV = 4'hF;

  // Bit positions within {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // FlagW fields: bit 1 enables the NZ update, bit 0 enables the CV update
  localparam int unsigned FLAGW_W     = 2;
  localparam int unsigned FLAGW_NZ_BIT = 1;
  localparam int unsigned FLAGW_CV_BIT = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational evaluation of an ARM condition field against NZCV.
module cond_check
  import arm_pkg::*;
(
  input  logic [COND_W-1:0]  Cond,
  input  logic [FLAGS_W-1:0] Flags,
  output logic               pass
);

  logic n, z, c, v;

  // Split out the individual flags for readability of the table
  always_comb begin
    n = Flags[FLAG_N];
    z = Flags[FLAG_Z];
    c = Flags[FLAG_C];
    v = Flags[FLAG_V];
  end

  // Condition table; the reserved 1111 encoding never passes
  always_comb begin
    pass = 1'b0;
    case (Cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = ~(n ^ v);
      COND_LT: pass = n ^ v;
      COND_GT: pass = ~z & ~(n ^ v);
      COND_LE: pass = z | (n ^ v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds NZCV, gates decoder write/branch requests.
module cond_unit
  import arm_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COND_W-1:0]   Cond,
  input  logic [FLAGS_W-1:0]  ALUFlags,
  input  logic [FLAGW_W-1:0]  FlagW,
  input  logic                PCS,
  input  logic                RegW,
  input  logic                MemW,
  input  logic                NoWrite,
  input  logic                Stall,
  output logic                PCSrc,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                CondEx,
  output logic [FLAGS_W-1:0]  Flags
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       cond_pass;

  assign Flags = {nz_q, cv_q};

  // Condition is judged against the committed flags only
  cond_check u_cond_check (
    .Cond  (Cond),
    .Flags (Flags),
    .pass  (cond_pass)
  );

  // Gated datapath enables; a stall kills every architectural effect
  always_comb begin
    CondEx   = cond_pass & ~Stall;
    PCSrc    = PCS & CondEx;
    RegWrite = RegW & CondEx & ~NoWrite;
    MemWrite = MemW & CondEx;
  end

  // Next flag values: each field updates independently, only when the instruction executes
  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (FlagW[FLAGW_NZ_BIT] && CondEx) nz_d = ALUFlags[FLAG_N:FLAG_Z];
    if (FlagW[FLAGW_CV_BIT] && CondEx) cv_d = ALUFlags[FLAG_C:FLAG_V];
  end

  // Flag register; reset wins over any pending update
  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= FLAG_RESET[FLAG_N:FLAG_Z];
      cv_q <= FLAG_RESET[FLAG_C:FLAG_V];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, Stall;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int checks   = 0;
  int failures = 0;

  cond_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .Stall    (Stall),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition model: base test on Cond[3:1], inverted by Cond[0]
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, b;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !b : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; Stall = 0;
  endtask

  // Load an arbitrary NZCV value through an AL flag-setting instruction
  task automatic set_flags(input logic [3:0] f);
    idle();
    FlagW = 2'b11; ALUFlags = f;
    tick();
    idle();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    Cond = 4'h0; RegW = 1'b1;
    #1;
    checks++; if (Flags !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b expected 0000", Flags); end
    checks++; if (CondEx !== 1'b0) begin failures++; $display("FAIL reset_eq_condex: got %b expected 0", CondEx); end
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_eq_regwrite: got %b expected 0", RegWrite); end
    Cond = 4'hE;
    #1;
    checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL reset_al_regwrite: got %b expected 1", RegWrite); end
  endtask

  task automatic test_cmp_beq();
    idle();
    // An instruction must not see its own ALUFlags
    Cond = 4'h0; ALUFlags = 4'b0100;
    #1;
    checks++; if (CondEx !== 1'b0) begin failures++; $display("FAIL own_aluflags_condex: got %b expected 0", CondEx); end
    Cond = 4'hE; FlagW = 2'b11; NoWrite = 1'b1; RegW = 1'b1; ALUFlags = 4'b0100;
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL cmp_regwrite: got %b expected 0", RegWrite); end
    checks++; if (CondEx !== 1'b1) begin failures++; $display("FAIL cmp_condex: got %b expected 1", CondEx); end
    tick();
    checks++; if (Flags !== 4'b0100) begin failures++; $display("FAIL cmp_flags: got %b expected 0100", Flags); end
    idle();
    Cond = 4'h0; PCS = 1'b1;
    #1;
    checks++; if (PCSrc !== 1'b1) begin failures++; $display("FAIL beq_pcsrc: got %b expected 1", PCSrc); end
  endtask

  task automatic test_partial_update();
    set_flags(4'b0110);
    Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b1001; RegW = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL ands_regwrite: got %b expected 1", RegWrite); end
    tick();
    checks++; if (Flags !== 4'b1010) begin failures++; $display("FAIL ands_flags: got %b expected 1010", Flags); end
    // CV-only update must leave NZ untouched
    set_flags(4'b0000);
    FlagW = 2'b01; ALUFlags = 4'b1111;
    tick();
    checks++; if (Flags !== 4'b0011) begin failures++; $display("FAIL cv_only_flags: got %b expected 0011", Flags); end
  endtask

  task automatic test_failed_cond();
    set_flags(4'b0100);
    Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b0000; RegW = 1'b1;
    #1;
    checks++; if (CondEx !== 1'b0) begin failures++; $display("FAIL subsne_condex: got %b expected 0", CondEx); end
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL subsne_regwrite: got %b expected 0", RegWrite); end
    tick();
    checks++; if (Flags !== 4'b0100) begin failures++; $display("FAIL subsne_flags: got %b expected 0100", Flags); end
  endtask

  task automatic test_stall();
    set_flags(4'b0100);
    Cond = 4'hE; MemW = 1'b1; PCS = 1'b1; RegW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1011; Stall = 1'b1;
    #1;
    checks++; if (MemWrite !== 1'b0) begin failures++; $display("FAIL stall_memwrite: got %b expected 0", MemWrite); end
    checks++; if ({CondEx, PCSrc, RegWrite} !== 3'b000) begin failures++; $display("FAIL stall_gated: got %b expected 000", {CondEx, PCSrc, RegWrite}); end
    tick();
    checks++; if (Flags !== 4'b0100) begin failures++; $display("FAIL stall_flags: got %b expected 0100", Flags); end
    Stall = 1'b0;
    #1;
    checks++; if (MemWrite !== 1'b1) begin failures++; $display("FAIL unstall_memwrite: got %b expected 1", MemWrite); end
    tick();
    checks++; if (Flags !== 4'b1011) begin failures++; $display("FAIL unstall_flags: got %b expected 1011", Flags); end
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      checks++; if (Flags !== 4'(f)) begin failures++; $display("FAIL sweep_load: got %b expected %b", Flags, 4'(f)); end
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        checks++;
        if (CondEx !== model_pass(4'(c), 4'(f))) begin
          failures++;
          $display("FAIL sweep_cond%0d_flags%b: got %b expected %b", c, 4'(f), CondEx, model_pass(4'(c), 4'(f)));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_flags(4'b0110);
    Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1101; reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++; if (Flags !== 4'b0000) begin failures++; $display("FAIL reset_mid_flags: got %b expected 0000", Flags); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_cmp_beq();
    test_partial_update();
    test_failed_cond();
    test_stall();
    test_sweep();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit of the single-cycle ARM core, sitting directly downstream of the instruction decoder. It holds the architectural NZCV flags and evaluates the instruction's condition field against them. It gates the decoder's raw write and branch requests (PCS, RegW, MemW) into the final datapath enables. Flag updates from the ALU are committed at the clock edge, but only for instructions whose condition passes.

## Interface
- FLAG_RESET, 4'b0000, NZCV value loaded on reset

- clk  in  1  core clock, rising-edge active
- reset  in  1  synchronous, active-high
- Cond  in  4  instruction bits [31:28]
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU for the current instruction
- FlagW  in  2  from decoder; [1] enables N,Z update; [0] enables C,V update
- PCS  in  1  decoder PC-write request
- RegW  in  1  decoder register-write request
- MemW  in  1  decoder memory-write request
- NoWrite  in  1  decoder compare indication (suppress Rd write)
- Stall  in  1  hold request; current instruction must have no architectural effect
- PCSrc  out  1  final PC-select to datapath
- RegWrite  out  1  final register-file write enable
- MemWrite  out  1  final data-memory write enable
- CondEx  out  1  condition-pass for the current instruction
- Flags  out  4  registered {N,Z,C,V}

## Operation
- Flag register: 2 independent fields, NZ = Flags[3:2] and CV = Flags[1:0].
- Condition evaluation uses the registered Flags only, never ALUFlags:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C & !Z
  - LS 1001: !C | Z
  - GE 1010: N == V
  - LT 1011: N != V
  - GT 1100: !Z & (N == V)
  - LE 1101: Z | (N != V)
  - AL 1110: 1
  - 1111 (unsupported): 0
- Enable gating:
  - CondEx = condition result & !Stall.
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & !NoWrite.
  - MemWrite = MemW & CondEx.
- Flag update at the clock edge:
  - NZ <= ALUFlags[3:2] when FlagW[1] & CondEx.
  - CV <= ALUFlags[1:0] when FlagW[0] & CondEx.
  - Otherwise each field holds its value.
- Reset: Flags <= FLAG_RESET, which takes priority over any update.
  - Reset output values with default parameter: Flags=0000, so Z=0.
  - Combinational outputs then follow their equations, e.g. Cond=EQ gives CondEx=0; Cond=AL with Stall=0 gives CondEx=1.

## Timing
- PCSrc, RegWrite, MemWrite and CondEx are combinational from the inputs and registered Flags; zero-cycle latency.
- Flags written by instruction i are visible to instruction i+1 (one-edge latency). An instruction never sees its own ALUFlags in its condition check.
- Stall high: all gated outputs are 0 and Flags hold, regardless of FlagW. Deasserting Stall re-evaluates against unchanged Flags.
- Partial update (FlagW=10, e.g. ANDS/ORRS): C and V are preserved bit-exact.
- Failed condition with FlagW=11 (e.g. CMPNE while Z=1): no flag change.
- Reset asserted mid-stream: Flags = FLAG_RESET after that edge, even if FlagW & CondEx were high in the same cycle.
- Only the registered Flags have a defined power-on value; there is no other state.

## Structure
- Shared package arm_pkg holds:
  - Condition-code constants COND_EQ … COND_AL, COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW field encodings.
- One combinational sub-module, cond_check (Cond, Flags -> pass), so the condition table can be verified exhaustively on its own.
- The top level holds the two flag-field registers and the gating logic.

## Test plan
- Reset, then Cond=0000 (EQ), RegW=1 -> CondEx=0, RegWrite=0, Flags=0000. Then Cond=1110 -> RegWrite=1.
- CMP (FlagW=11, NoWrite=1, RegW=1, Cond=AL, ALUFlags=0100) -> RegWrite=0 in that cycle; Flags=0100 after the edge; next BEQ (PCS=1, Cond=0000) -> PCSrc=1.
- Flags=0110; ANDS with FlagW=10, ALUFlags=1001 -> Flags=1010 (C,V preserved).
- Flags=0100; SUBSNE (Cond=0001, FlagW=11, ALUFlags=0000) -> CondEx=0, Flags stay 0100, RegWrite=0.
- Stall=1 with Cond=AL, MemW=1, FlagW=11 -> MemWrite=0 and Flags unchanged. Stall=0 on the next cycle -> MemWrite=1 and the flag update occurs.
- Exhaustive sweep: all 16 Cond × 16 Flags compared against a model of the table. Then reset asserted concurrently with a flag-setting instruction -> Flags=0000.
